// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: execute-stage beat sequencer sweeping a vector op over the ALU pool.
// Optional: VSEQ_SCALAR_BYPASS_EN collapses OpType 00 launches to a single lane-0 beat.

module vector_lane_sequencer #(
  parameter int LANES     = 8,
  parameter int ALU_COUNT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     Start,
  input  logic [1:0]               OpType,
  input  logic                     Stall,
  input  logic                     Retire,
  output logic                     Busy,
  output logic                     LaneValid,
  output logic [$clog2(LANES)-1:0] LaneBase,
  output logic [ALU_COUNT-1:0]     LaneMask,
  output logic                     Exe_Finished
);

  localparam int BW = $clog2(LANES);

  localparam logic [BW:0] STEP = (BW+1)'(ALU_COUNT);
  localparam logic [BW:0] LIM  = (BW+1)'(LANES);

  localparam logic [ALU_COUNT-1:0] LANE0 = ALU_COUNT'(1);

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_DONE = 3'b100;

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [BW-1:0]        base_q;
  logic [BW-1:0]        base_d;
  logic [1:0]           op_q;
  logic [1:0]           op_d;
  logic [BW:0]          base_sum;
  logic                 last_beat;
  logic                 scalar;
  logic [ALU_COUNT-1:0] mask_full;

`ifdef VSEQ_SCALAR_BYPASS_EN
  assign scalar = (op_q == 2'b00);
`else
  logic unused_op;
  assign scalar    = 1'b0;
  assign unused_op = ^op_q;
`endif

  // One extra bit so the step past the last lane cannot wrap.
  assign base_sum  = {1'b0, base_q} + STEP;
  assign last_beat = scalar | (base_sum >= LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      op_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    op_d    = op_q;
    unique case (1'b1)
      state_q[0]: begin
        if (Start) begin
          state_d = S_RUN;
          base_d  = '0;
          op_d    = OpType;
        end
      end
      state_q[1]: begin
        if (!Stall) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            base_d = base_sum[BW-1:0];
          end
        end
      end
      state_q[2]: begin
        if (Retire) begin
          base_d = '0;
          if (Start) begin
            state_d = S_RUN;
            op_d    = OpType;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        base_d  = '0;
      end
    endcase
  end

  always_comb begin
    mask_full = '0;
    for (int i = 0; i < ALU_COUNT; i++) begin
      mask_full[i] = ({1'b0, base_q} + (BW+1)'(i)) < LIM;
    end
  end

  always_comb begin
    Busy         = state_q[1] | state_q[2];
    LaneValid    = state_q[1];
    LaneBase     = base_q;
    Exe_Finished = state_q[2];
    LaneMask     = '0;
    if (state_q[1]) begin
      LaneMask = scalar ? LANE0 : mask_full;
    end
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot(state_q));

  a_base_range: assert property (
    @(posedge clk) disable iff (rst) ({1'b0, base_q} < LIM));

endmodule
